mac_rx_parser: RTL and testbench

MAC_RX_PARSER -- requirements
Module: mac_rx_parser

---
 rtl/mac_pkg.sv | 23 ++
 rtl/skid_buf2.sv | 54 +++++
 rtl/mac_rx_parser.sv | 154 +++++++++++++++
 tb/tb_mac_rx_parser.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
`default_nettype none
// ============================================================================
// mac_pkg : shared pointer-word layout, header size and parser FSM states
// Revision 1.0
// ============================================================================
package mac_pkg;
    localparam int PTR_ERR_BIT = 15;
    localparam int PTR_LEN_MSB = 11;
    localparam int PTR_LEN_W   = 12;
    localparam int ETH_HDR_LEN = 14;
    localparam int DEF_MAX_LEN = 1518;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PTR_WAIT = 3'd1,
        CHECK    = 3'd2,
        HDR      = 3'd3,
        HDR_OUT  = 3'd4,
        PAYLOAD  = 3'd5,
        DROP     = 3'd6
    } mac_state_t;
endpackage
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// ============================================================================
// skid_buf2 : two-entry buffer with the head entry driven straight from a flop
// Revision 1.0
// ============================================================================
module skid_buf2 #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);
    logic [WIDTH-1:0] tail;
    logic             pop;

    assign out_valid = (level != 2'd0);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level    <= 2'd0;
            out_data <= '0;
            tail     <= '0;
        end else begin
            case ({in_valid, pop})
                2'b10: begin
                    if (level == 2'd0) out_data <= in_data;
                    else               tail     <= in_data;
                    if (level != 2'd2) level <= level + 2'd1;
                end
                2'b01: begin
                    out_data <= tail;
                    level    <= level - 2'd1;
                end
                2'b11: begin
                    // Level stays the same; only the entries move.
                    if (level == 2'd2) begin
                        out_data <= tail;
                        tail     <= in_data;
                    end else begin
                        out_data <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/mac_rx_parser.sv
`default_nettype none
// ============================================================================
// mac_rx_parser : pops pointer/data FIFOs, emits header descriptor and payload
// Revision 1.0
// ============================================================================
module mac_rx_parser
    import mac_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int MIN_LEN = ETH_HDR_LEN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ptr_fifo_empty,
    output logic        ptr_fifo_rd,
    input  logic [15:0] ptr_fifo_din,
    output logic        data_fifo_rd,
    input  logic [7:0]  data_fifo_din,
    output logic        hdr_valid,
    input  logic        hdr_ready,
    output logic [47:0] hdr_da,
    output logic [47:0] hdr_sa,
    output logic [15:0] hdr_type,
    output logic [11:0] hdr_len,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic [15:0] drop_cnt
);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);
    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] HDR_L = 12'(ETH_HDR_LEN);

    mac_state_t             state;
    logic                   armed;
    logic                   ptr_err;
    logic [PTR_LEN_W-1:0]   ptr_len;
    logic [11:0]            rd_cnt;
    logic                   rd_d;
    logic [111:0]           hdr_sr;
    logic                   unused_rsv;
    logic [1:0]             sk_level;
    logic                   sk_push;
    logic                   sk_pop;
    logic [9:0]             sk_din;
    logic [9:0]             sk_dout;
    logic [2:0]             occ;
    logic                   pay_rd;

    // Bits [14:12] of the pointer word carry nothing this block uses.
    assign unused_rsv = ^ptr_fifo_din[14:12];

    // armed keeps the pointer pop low through reset and the cycle after it.
    assign ptr_fifo_rd = armed && (state == IDLE) && !ptr_fifo_empty;

    // Occupancy after this cycle's pop, plus the byte still in flight.
    assign sk_pop = out_valid && out_ready;
    assign occ    = {1'b0, sk_level} + {2'b00, rd_d} - {2'b00, sk_pop};
    assign pay_rd = (state == PAYLOAD) && (rd_cnt < hdr_len) && (occ < 3'd2);

    assign data_fifo_rd = ((state == HDR)  && (rd_cnt < HDR_L))   ||
                          ((state == DROP) && (rd_cnt < ptr_len)) ||
                          pay_rd;

    // rd_cnt already counts the read whose byte is arriving now.
    assign sk_push = (state == PAYLOAD) && rd_d;
    assign sk_din  = {(rd_cnt == hdr_len), (rd_cnt == 12'd1), data_fifo_din};

    assign hdr_da   = hdr_sr[111:64];
    assign hdr_sa   = hdr_sr[63:16];
    assign hdr_type = hdr_sr[15:0];

    assign out_data = sk_dout[7:0];
    assign out_sof  = sk_dout[8];
    assign out_eof  = sk_dout[9];

    skid_buf2 #(
        .WIDTH(10)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (sk_push),
        .in_data   (sk_din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (sk_dout),
        .level     (sk_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            armed     <= 1'b0;
            ptr_err   <= 1'b0;
            ptr_len   <= '0;
            rd_cnt    <= '0;
            rd_d      <= 1'b0;
            hdr_sr    <= '0;
            hdr_len   <= '0;
            hdr_valid <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            armed <= 1'b1;
            rd_d  <= data_fifo_rd;
            if (data_fifo_rd) rd_cnt <= rd_cnt + 12'd1;
            case (state)
                IDLE: begin
                    if (ptr_fifo_rd) state <= PTR_WAIT;
                end
                PTR_WAIT: begin
                    ptr_err <= ptr_fifo_din[PTR_ERR_BIT];
                    ptr_len <= ptr_fifo_din[PTR_LEN_MSB:0];
                    state   <= CHECK;
                end
                CHECK: begin
                    rd_cnt <= '0;
                    if (ptr_err || (ptr_len < MIN_L) || (ptr_len > MAX_L)) begin
                        state <= DROP;
                    end else begin
                        hdr_len <= ptr_len - HDR_L;
                        state   <= HDR;
                    end
                end
                HDR: begin
                    if (rd_d) hdr_sr <= {hdr_sr[103:0], data_fifo_din};
                    if (rd_cnt == HDR_L) begin
                        hdr_valid <= 1'b1;
                        state     <= HDR_OUT;
                    end
                end
                HDR_OUT: begin
                    if (hdr_ready) begin
                        hdr_valid <= 1'b0;
                        rd_cnt    <= '0;
                        state     <= (hdr_len != 12'd0) ? PAYLOAD : IDLE;
                    end
                end
                PAYLOAD: begin
                    if (sk_pop && out_eof) state <= IDLE;
                end
                DROP: begin
                    if (rd_cnt == ptr_len) begin
                        if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mac_rx_parser.sv
`default_nettype none
// ============================================================================
// tb_mac_rx_parser : table-driven frame vectors plus a mid-frame reset case
// Revision 1.0
// ============================================================================
module tb_mac_rx_parser;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ptr_fifo_empty = 1'b1;
    logic        ptr_fifo_rd;
    logic [15:0] ptr_fifo_din = 16'h0000;
    logic        data_fifo_rd;
    logic [7:0]  data_fifo_din = 8'h00;
    logic        hdr_valid;
    logic        hdr_ready = 1'b1;
    logic [47:0] hdr_da, hdr_sa;
    logic [15:0] hdr_type;
    logic [11:0] hdr_len;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic        out_sof, out_eof;
    logic [15:0] drop_cnt;

    mac_rx_parser #(.MAX_LEN(1518), .MIN_LEN(14)) dut (
        .clk(clk), .rst(rst),
        .ptr_fifo_empty(ptr_fifo_empty), .ptr_fifo_rd(ptr_fifo_rd), .ptr_fifo_din(ptr_fifo_din),
        .data_fifo_rd(data_fifo_rd), .data_fifo_din(data_fifo_din),
        .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
        .hdr_da(hdr_da), .hdr_sa(hdr_sa), .hdr_type(hdr_type), .hdr_len(hdr_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eof(out_eof), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] ptr;
        logic [7:0]  seed;
        logic        toggle;
        int          hdelay;
        int          reads;
        int          hdr;
        logic [47:0] da;
        logic [47:0] sa;
        logic [15:0] etype;
        logic [11:0] hlen;
        int          drop;
    } vec_t;

    vec_t vecs[11];
    int checks = 0;
    int errors = 0;

    // stimulus requests (written by the main initial block only)
    int          load_n = 0, flush_n = 0, load_bytes = 0;
    logic [15:0] load_ptr = 16'h0;
    logic [7:0]  load_seed = 8'h0;
    logic        toggle = 1'b0;
    int          hdr_delay = 0;

    // FIFO models and posedge monitor state
    logic [15:0] ptr_q[$];
    logic [7:0]  dat_q[$];
    int load_seen = 0, flush_seen = 0;
    int rd_total = 0, ptr_bad = 0, underflow = 0, cyc = 0;
    int win_rd = 0, win_acc = 0, cur_max = 0;
    int rcyc_log[$];

    always @(posedge clk) begin
        if (load_n != load_seen) begin
            load_seen = load_n;
            ptr_q.push_back(load_ptr);
            for (int i = 0; i < load_bytes; i++) dat_q.push_back(8'(load_seed + i));
        end
        if (flush_n != flush_seen) begin
            flush_seen = flush_n;
            ptr_q.delete();
            dat_q.delete();
        end
        if (ptr_fifo_rd) begin
            if (ptr_fifo_empty || ptr_q.size() == 0) ptr_bad++;
            else ptr_fifo_din <= ptr_q.pop_front();
        end
        ptr_fifo_empty <= (ptr_q.size() == 0);
        if (data_fifo_rd) begin
            rd_total++;
            win_rd++;
            rcyc_log.push_back(cyc);
            if (dat_q.size() == 0) begin
                underflow++;
                data_fifo_din <= 8'h00;
            end else begin
                data_fifo_din <= dat_q.pop_front();
            end
        end
        if (out_valid && out_ready) win_acc++;
        if (win_rd - win_acc > cur_max) cur_max = win_rd - win_acc;
        if (hdr_valid && hdr_ready) begin
            win_rd = 0; win_acc = 0; cur_max = 0;
        end
        cyc++;
    end

    // ready drivers, changed just after each rising edge
    int hcnt = 0;
    always @(posedge clk) begin
        #1;
        out_ready = toggle ? ~out_ready : 1'b1;
        if (hdr_valid && hcnt < hdr_delay) begin
            hdr_ready = 1'b0;
            hcnt++;
        end else begin
            hdr_ready = 1'b1;
            if (!hdr_valid) hcnt = 0;
        end
    end

    // negedge monitor: captures, stall stability, reads under reset
    logic [9:0]   out_log[$];
    int           vcyc_log[$];
    int           hdr_total = 0, stab_err = 0, hstab_err = 0, rd_rst = 0;
    logic [47:0]  cap_da = '0, cap_sa = '0;
    logic [15:0]  cap_type = '0;
    logic [11:0]  cap_len = '0;
    logic         p_ov = 1'b0, p_or = 1'b0, p_hv = 1'b0, p_hr = 1'b0;
    logic [9:0]   p_od = '0;
    logic [123:0] p_h = '0;

    always @(negedge clk) begin
        if (rst && (ptr_fifo_rd || data_fifo_rd)) rd_rst++;
        if (out_valid) vcyc_log.push_back(cyc);
        if (out_valid && out_ready) out_log.push_back({out_eof, out_sof, out_data});
        if (!rst && p_ov && !p_or && (!out_valid || {out_eof, out_sof, out_data} != p_od)) stab_err++;
        if (hdr_valid && hdr_ready) begin
            hdr_total++;
            cap_da = hdr_da; cap_sa = hdr_sa; cap_type = hdr_type; cap_len = hdr_len;
        end
        if (!rst && p_hv && !p_hr && (!hdr_valid || {hdr_da, hdr_sa, hdr_type, hdr_len} != p_h)) hstab_err++;
        p_ov = out_valid; p_or = out_ready; p_od = {out_eof, out_sof, out_data};
        p_hv = hdr_valid; p_hr = hdr_ready; p_h = {hdr_da, hdr_sa, hdr_type, hdr_len};
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " strobes"}, 64'({ptr_fifo_rd, data_fifo_rd, hdr_valid, out_valid, out_sof, out_eof}), 64'd0);
        chk({tag, " hdr_da"}, 64'(hdr_da), 64'd0);
        chk({tag, " hdr_sa"}, 64'(hdr_sa), 64'd0);
        chk({tag, " type/len/data/drop"}, 64'({hdr_type, hdr_len, out_data, drop_cnt}), 64'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int r0, h0, o0, v0, rc0, s0, hs0, tmo, nb, bad, got;
        logic [9:0] exp_b;
        string t;
        t   = $sformatf("v%0d", idx);
        r0  = rd_total; h0 = hdr_total; o0 = out_log.size(); v0 = vcyc_log.size();
        rc0 = rcyc_log.size(); s0 = stab_err; hs0 = hstab_err;
        toggle = v.toggle; hdr_delay = v.hdelay;
        load_ptr = v.ptr; load_seed = v.seed; load_bytes = int'(v.ptr[11:0]);
        load_n++;
        @(negedge clk);
        tmo = 0;
        while ((ptr_q.size() != 0 || dat_q.size() != 0) && tmo < 5000) begin
            @(negedge clk);
            tmo++;
        end
        chk({t, " drained"}, 64'(tmo < 5000), 64'd1);
        if (tmo >= 5000) flush_n++;
        repeat (12) @(negedge clk);

        nb  = (v.hdr != 0) ? int'(v.hlen) : 0;
        got = out_log.size() - o0;
        chk({t, " data reads"}, 64'(rd_total - r0), 64'(v.reads));
        chk({t, " hdr count"}, 64'(hdr_total - h0), 64'(v.hdr));
        if (v.hdr != 0) begin
            chk({t, " hdr_da"}, 64'(cap_da), 64'(v.da));
            chk({t, " hdr_sa"}, 64'(cap_sa), 64'(v.sa));
            chk({t, " hdr_type"}, 64'(cap_type), 64'(v.etype));
            chk({t, " hdr_len"}, 64'(cap_len), 64'(v.hlen));
        end
        chk({t, " payload bytes"}, 64'(got), 64'(nb));
        if (nb > 0) begin
            bad = 0;
            for (int k = 0; k < nb && k < got; k++) begin
                exp_b = {(k == nb - 1), (k == 0), 8'(v.seed + 14 + k)};
                if (out_log[o0 + k] !== exp_b) bad++;
            end
            chk({t, " payload content/sof/eof"}, 64'(bad), 64'd0);
            if (rcyc_log.size() > rc0 + 14 && vcyc_log.size() > v0)
                chk({t, " first out latency"}, 64'(vcyc_log[v0] - rcyc_log[rc0 + 14]), 64'd2);
            chk({t, " max outstanding<=2"}, 64'(cur_max <= 2), 64'd1);
        end
        if (!v.toggle) begin
            chk({t, " out_valid cycles"}, 64'(vcyc_log.size() - v0), 64'(nb));
            if (nb > 0 && vcyc_log.size() > v0)
                chk({t, " back-to-back span"}, 64'(vcyc_log[vcyc_log.size() - 1] - vcyc_log[v0] + 1), 64'(nb));
        end
        if (v.toggle || v.hdelay != 0)
            chk({t, " stall stability"}, 64'((stab_err - s0) + (hstab_err - hs0)), 64'd0);
        chk({t, " drop_cnt"}, 64'(drop_cnt), 64'(v.drop));
    endtask

    initial begin
        int a0, rr0, tmo;
        vec_t post;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        vecs[0]  = '{16'h0040, 8'h00, 1'b0, 0, 64,   1, 48'h000102030405, 48'h060708090A0B, 16'h0C0D, 12'd50,   0};
        vecs[1]  = '{16'h8040, 8'h00, 1'b0, 0, 64,   0, 48'h0, 48'h0, 16'h0, 12'd0, 1};
        vecs[2]  = '{16'h000E, 8'h20, 1'b0, 2, 14,   1, 48'h202122232425, 48'h262728292A2B, 16'h2C2D, 12'd0,    1};
        vecs[3]  = '{16'h05FF, 8'h00, 1'b0, 0, 1535, 0, 48'h0, 48'h0, 16'h0, 12'd0, 2};
        vecs[4]  = '{16'h0040, 8'h40, 1'b0, 0, 64,   1, 48'h404142434445, 48'h464748494A4B, 16'h4C4D, 12'd50,   2};
        vecs[5]  = '{16'h0064, 8'h80, 1'b1, 3, 100,  1, 48'h808182838485, 48'h868788898A8B, 16'h8C8D, 12'd86,   2};
        vecs[6]  = '{16'h8000, 8'h00, 1'b0, 0, 0,    0, 48'h0, 48'h0, 16'h0, 12'd0, 3};
        vecs[7]  = '{16'h7040, 8'h10, 1'b0, 1, 64,   1, 48'h101112131415, 48'h161718191A1B, 16'h1C1D, 12'd50,   3};
        vecs[8]  = '{16'h000D, 8'h00, 1'b0, 0, 13,   0, 48'h0, 48'h0, 16'h0, 12'd0, 4};
        vecs[9]  = '{16'h05EE, 8'h00, 1'b0, 0, 1518, 1, 48'h000102030405, 48'h060708090A0B, 16'h0C0D, 12'd1504, 4};
        vecs[10] = '{16'h05EF, 8'h00, 1'b1, 0, 1519, 0, 48'h0, 48'h0, 16'h0, 12'd0, 5};

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

        // reset in the middle of a payload
        toggle = 1'b0; hdr_delay = 0;
        a0 = out_log.size();
        load_ptr = 16'h0064; load_seed = 8'h55; load_bytes = 100;
        load_n++;
        tmo = 0;
        while (out_log.size() - a0 < 20 && tmo < 2000) begin
            @(negedge clk);
            tmo++;
        end
        chk("midrst reached byte 20", 64'(tmo < 2000), 64'd1);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        rr0 = rd_rst;
        flush_n++;
        repeat (3) @(negedge clk);
        chk("midrst reads under rst", 64'(rd_rst - rr0), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        post = '{16'h0040, 8'hA0, 1'b1, 0, 64, 1, 48'hA0A1A2A3A4A5, 48'hA6A7A8A9AAAB, 16'hACAD, 12'd50, 0};
        run_vec(11, post);

        chk("ptr_rd while empty", 64'(ptr_bad), 64'd0);
        chk("data fifo underflow", 64'(underflow), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
